// File: rtl/processor_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   INSTR_W             : instruction word width written to memory
//   BYTE_W              : width of one stream byte
//   imem_loader_state_t : loader FSM state encoding
package processor_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } imem_loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
//   rx_data/rx_valid/rx_ready : valid/ready byte stream into the loader
//   wr_en/wr_addr/wr_data     : one-cycle write strobe, address and word
// modport master : boot host / memory side
// modport slave  : the loader
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    import processor_pkg::*;

    logic [BYTE_W-1:0]  rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/loader_checksum.sv
// XOR accumulator over the frame bytes.
//   clk, reset : clock, async active-low reset
//   clear      : zero the accumulator (takes priority over update)
//   update     : fold data into the accumulator
//   data       : current stream byte
//   match      : accumulator equals data (used on the CHECK byte)
module loader_checksum
    import processor_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              update,
    input  logic [BYTE_W-1:0] data,
    output logic              match
);

    logic [BYTE_W-1:0] acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (update) begin
            acc <= acc ^ data;
        end
    end

    assign match = (acc == data);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer. Receives COUNT, COUNT little-endian
// 16-bit words and an XOR CHECK byte, writes the words to consecutive
// addresses from START_ADDR and releases the core only on a clean load.
//   clk, reset : clock, async active-low reset
//   start      : one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   bus        : byte stream in, memory write strobe/address/data out
//   cpu_hold   : holds the processor core in reset while 1
//   load_done  : load finished with matching checksum
//   load_error : checksum mismatch
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | after reset, waiting for start
// COUNT    | waiting for the word-count byte
// LO       | waiting for the low byte of a word
// HI       | waiting for the high byte; accept schedules the write
// CHECK    | waiting for the checksum byte
// DONE     | load good, core released
// ERROR    | checksum bad, core held
module imem_loader
    import processor_pkg::*;
#(
    parameter int              ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_error
);

    // Counter is wide enough for both a full byte and 2^ADDR_W.
    localparam int CNT_W = ((ADDR_W > BYTE_W) ? ADDR_W : BYTE_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << ADDR_W;

    imem_loader_state_t state, state_nxt;

    logic              rx_ready;
    logic              accept;
    logic              load_start;
    logic              cs_update;
    logic              cs_match;
    logic              last_word;
    logic [CNT_W-1:0]  word_cnt;
    logic [ADDR_W-1:0] ptr;
    logic [BYTE_W-1:0] lo_byte;

    assign accept       = bus.rx_valid && rx_ready;
    assign last_word    = (word_cnt == CNT_W'(1));
    assign bus.rx_ready = rx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rx_ready   = 1'b0;
        load_start = 1'b0;
        cs_update  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    load_start = 1'b1;
                    state_nxt  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                rx_ready = 1'b1;
                if (accept) begin
                    cs_update = 1'b1;
                    state_nxt = ST_LO;
                end
            end
            ST_LO: begin
                rx_ready = 1'b1;
                if (accept) begin
                    cs_update = 1'b1;
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                rx_ready = 1'b1;
                if (accept) begin
                    cs_update = 1'b1;
                    state_nxt = last_word ? ST_CHECK : ST_LO;
                end
            end
            ST_CHECK: begin
                rx_ready = 1'b1;
                if (accept) begin
                    state_nxt = cs_match ? ST_DONE : ST_ERROR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The write register is loaded on the HI accept, so the strobe appears
    // one cycle later while the FSM is already taking the next LO byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt    <= '0;
            ptr         <= START_ADDR;
            lo_byte     <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= START_ADDR;
            bus.wr_data <= '0;
            cpu_hold    <= 1'b1;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            if (load_start) begin
                cpu_hold   <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
                ptr        <= START_ADDR;
            end
            if (accept) begin
                case (state)
                    ST_COUNT: begin
                        word_cnt <= (bus.rx_data == '0) ? CNT_FULL
                                                        : CNT_W'(bus.rx_data);
                    end
                    ST_LO: begin
                        lo_byte <= bus.rx_data;
                    end
                    ST_HI: begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= ptr;
                        bus.wr_data <= {bus.rx_data, lo_byte};
                        ptr         <= ptr + ADDR_W'(1);
                        word_cnt    <= word_cnt - CNT_W'(1);
                    end
                    ST_CHECK: begin
                        if (cs_match) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    loader_checksum u_checksum (
        .clk    (clk),
        .reset  (reset),
        .clear  (load_start),
        .update (cs_update),
        .data   (bus.rx_data),
        .match  (cs_match)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Writes are captured by a monitor and
// compared against a frame-level reference model; done/error/hold outcomes
// come from a vector table and hand-written sequences.
module tb_imem_loader;
    import processor_pkg::*;

    localparam int          ADDR_W = 8;
    localparam logic [7:0]  START  = 8'hFE;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, load_done, load_error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .START_ADDR(START)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    typedef struct {
        int         cnt;
        logic [7:0] corrupt;
        bit         gaps;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    wr_t got[$];
    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) got.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: expected writes and checksum verdict straight from the frame rules.
    function automatic bit model(input byte_q_t f);
        int n;
        logic [7:0] x;
        n = (f[0] == 8'h00) ? 256 : int'(f[0]);
        x = 8'h00;
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back('{addr: 8'(int'(START) + i), data: {f[2 + 2*i], f[1 + 2*i]}});
        for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
        return f[f.size() - 1] == x;
    endfunction

    function automatic byte_q_t make_frame(input int cnt, input logic [7:0] corrupt);
        byte_q_t q;
        int n;
        logic [7:0] x, b;
        b = cnt[7:0];
        q.push_back(b);
        x = b;
        n = (cnt == 0) ? 256 : cnt;
        for (int i = 0; i < 2*n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x ^= b;
        end
        q.push_back(x ^ corrupt);
        return q;
    endfunction

    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the last accept.
    task automatic send(input byte_q_t f, input bit gaps, input int start_at);
        int idx;
        int budget;
        bit acc;
        idx = 0;
        budget = 40 * f.size() + 100;
        while (idx < f.size()) begin
            bus.rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.rx_data  = bus.rx_valid ? f[idx] : 8'($urandom);
            start        = (start_at >= 0 && idx == start_at);
            acc          = bus.rx_valid && bus.rx_ready;
            @(posedge clk);
            if (acc) idx++;
            budget--;
            if (budget == 0) begin
                chk("send_timeout", idx, f.size());
                break;
            end
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input byte_q_t f);
        int n;
        void'(model(f));
        repeat (3) @(negedge clk);
        chk($sformatf("%s_nwrites", tag), got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), {got[i].addr, got[i].data},
                {exp_q[i].addr, exp_q[i].data});
    endtask

    task automatic check_outcome(input string tag, input bit done, input bit err);
        chk({tag, "_done"}, load_done, done);
        chk({tag, "_err"}, load_error, err);
        chk({tag, "_hold"}, cpu_hold, !done);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
        chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
        chk({tag, "_wr_addr"}, bus.wr_addr, START);
        chk({tag, "_wr_data"}, bus.wr_data, 16'h0000);
        chk({tag, "_hold"}, cpu_hold, 1'b1);
        chk({tag, "_done"}, load_done, 1'b0);
        chk({tag, "_err"}, load_error, 1'b0);
    endtask

    initial begin
        byte_q_t nom, nom_head, nom_tail, bad_f, part, f;
        vec_t vecs[6];
        int n0;

        vecs[0] = '{cnt: 2, corrupt: 8'h00, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{cnt: 2, corrupt: 8'h01, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[2] = '{cnt: 1, corrupt: 8'h00, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{cnt: 7, corrupt: 8'h00, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{cnt: 3, corrupt: 8'h80, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
        vecs[5] = '{cnt: 4, corrupt: 8'h00, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

        nom      = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        nom_head = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
        nom_tail = '{8'h0A};
        bad_f    = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B};
        part     = '{8'h02, 8'h34};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state, then stray valid bytes in IDLE must be ignored.
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk("idle_rx_ready", bus.rx_ready, 1'b0);
        bus.rx_valid = 1'b0;
        chk("idle_nwrites", got.size(), 0);

        // Nominal frame; hold must drop exactly one cycle after CHECK accept.
        do_start();
        chk("nom_rx_ready", bus.rx_ready, 1'b1);
        got.delete();
        send(nom_head, 1'b0, -1);
        chk("nom_hold_before", cpu_hold, 1'b1);
        chk("nom_done_before", load_done, 1'b0);
        send(nom_tail, 1'b0, -1);
        chk("nom_hold_after", cpu_hold, 1'b0);
        check_writes("nom", nom);
        check_outcome("nom", 1'b1, 1'b0);

        // Stray valid bytes in DONE change nothing.
        n0 = got.size();
        bus.rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("done_idle_nwrites", got.size(), n0);
        check_outcome("done_idle", 1'b1, 1'b0);

        // Bad checksum: words still written, core stays held.
        do_start();
        chk("bad_done_cleared", load_done, 1'b0);
        got.delete();
        send(bad_f, 1'b0, -1);
        check_writes("badck", bad_f);
        check_outcome("badck", 1'b0, 1'b1);

        // Restart after ERROR, with a start pulse landing in HI that must be ignored.
        do_start();
        chk("restart_err_cleared", load_error, 1'b0);
        got.delete();
        send(nom, 1'b0, 2);
        check_writes("midstart", nom);
        check_outcome("midstart", 1'b1, 1'b0);

        // Backpressure / gaps on the nominal frame.
        for (int r = 0; r < 3; r++) begin
            do_start();
            got.delete();
            send(nom, 1'b1, -1);
            check_writes($sformatf("gap%0d", r), nom);
            check_outcome($sformatf("gap%0d", r), 1'b1, 1'b0);
        end

        // Vector table with random payloads.
        for (int v = 0; v < 6; v++) begin
            f = make_frame(vecs[v].cnt, vecs[v].corrupt);
            do_start();
            got.delete();
            send(f, vecs[v].gaps, -1);
            check_writes($sformatf("vec%0d", v), f);
            check_outcome($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
        end

        // COUNT=0 means a full 256-word image; address wraps through FF->00.
        f = make_frame(0, 8'h00);
        do_start();
        got.delete();
        send(f, 1'b0, -1);
        check_writes("full", f);
        check_outcome("full", 1'b1, 1'b0);
        if (got.size() == 256) begin
            chk("full_first_addr", got[0].addr, 8'hFE);
            chk("full_wrap_addr", got[2].addr, 8'h00);
            chk("full_last_addr", got[255].addr, 8'hFD);
        end else begin
            chk("full_size_for_addr", got.size(), 256);
        end

        // Reset asserted mid-load, then a clean reload.
        do_start();
        got.delete();
        send(part, 1'b0, -1);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        do_start();
        got.delete();
        send(nom, 1'b0, -1);
        check_writes("postrst", nom);
        check_outcome("postrst", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory; the processor core is the reader of that memory.
- Accepts a framed byte stream through a valid/ready interface and assembles little-endian 16-bit instruction words.
- Writes each word to consecutive instruction-memory addresses, checks a trailing XOR checksum, and holds the core in reset until a load completes cleanly.

Parameters:
- ADDR_W, 8, instruction-memory address width; a count byte of 0 means 2^ADDR_W words.
- START_ADDR, 0, address written by the first word; later addresses increment and wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  one-cycle pulse; begins a load in IDLE, DONE or ERROR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid and rx_ready are both 1
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  write address
- wr_data  out  16  instruction word
- cpu_hold  out  1  holds the processor core in reset while 1
- load_done  out  1  level; load finished and checksum matched
- load_error  out  1  level; checksum mismatch

Behaviour:
- Reset values: state=IDLE, rx_ready=0, wr_en=0, wr_addr=START_ADDR, wr_data=0, cpu_hold=1, load_done=0, load_error=0, checksum=0.
- Frame format: COUNT byte, then COUNT words (each sent as low byte then high byte), then one CHECK byte. The frame is valid when CHECK equals the XOR of all preceding bytes, including COUNT.
- States: IDLE, COUNT, LO, HI, CHECK, DONE, ERROR.
- rx_ready is 1 only in COUNT, LO, HI and CHECK. The loader never stalls inside those states.
- A transfer is accepted on any cycle with rx_valid=1 and rx_ready=1.
- Transitions:
  - IDLE/DONE/ERROR --start--> COUNT. On this transition: cpu_hold=1, load_done=0, load_error=0, checksum=0, address pointer=START_ADDR.
  - COUNT --accept--> LO. Word counter loads the byte; a byte of 0 loads 2^ADDR_W. Checksum ^= byte.
  - LO --accept--> HI. Low byte is latched; checksum ^= byte.
  - HI --accept--> LO, or to CHECK if this was the last word.
    - The cycle after the HI accept: wr_en=1, wr_data={hi,lo}, wr_addr=pointer.
    - The pointer then increments (wraps) and the word counter decrements.
    - Checksum ^= byte.
  - CHECK --accept--> DONE if the byte equals the checksum, otherwise ERROR.
    - DONE: load_done=1 and cpu_hold=0 from the next cycle.
    - ERROR: load_error=1 and cpu_hold stays 1.
- wr_en is a single-cycle pulse, exactly one per word. wr_addr and wr_data are stable while wr_en=1 and hold their last values otherwise.
- Throughput: one byte per cycle with rx_valid held high. A back-to-back HI byte followed by the next LO byte is legal; the write pipeline register does not block acceptance.
- start outside IDLE/DONE/ERROR is ignored; a load in progress is never restarted.
- rx_valid without rx_ready: no state change, no checksum update.
- Reset asserted mid-load: immediate return to reset values. Any partially written words remain in memory, but cpu_hold=1 prevents their execution until a successful reload.
- load_done and load_error are never 1 simultaneously.
- Words already written before an ERROR are not rolled back.

Decomposition:
- Shared package (processor_pkg): the state enum type imem_loader_state_t, the INSTR_W=16 constant, and the byte-width constant.
- Natural sub-module: loader_checksum. It holds the XOR accumulator with clear, update and compare; it is instantiated once.
- The FSM, word counter, address pointer and write register live in imem_loader.

Test Plan:
- Nominal load: start, then bytes 02, 34,12, 78,56, checksum 02^34^12^78^56=0A. Required: writes (00,1234) and (01,5678), each with wr_en high for exactly one cycle; load_done=1; cpu_hold falls to 0 one cycle after the CHECK accept.
- Bad checksum: same frame with CHECK=0B. Required: load_error=1, cpu_hold remains 1, load_done=0. Both words are still written.
- Backpressure and gaps: same frame with rx_valid toggled randomly. Required: identical writes and the same final state; no byte is counted twice.
- Count=0 with START_ADDR=0xFE: stream 256 words. Required: the first write goes to FE, the address wraps to 00 after FF, the last write goes to FD, then load_done asserts.
- Reset mid-load: pull reset low after the first LO byte. Required: all outputs return to reset values, cpu_hold=1, rx_ready=0. A fresh start followed by the nominal frame then succeeds.
- Start during load: pulse start while in HI. Required: the pulse is ignored and the frame completes normally. A start after ERROR clears load_error and reloads successfully.
